// File: rtl/rf_pkg.sv
// Shared types, default sizes and bus-slicing helpers for the multi-port register file.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    // Low bit of lane `port` in a flattened bus whose lanes are `width` bits wide.
    function automatic int unsigned lo_bit(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port: stored entry, overridden by the highest-index matching write port,
// then forced to zero while clearing or when reading the hardwired zero register.
module rf_bypass_mux
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AW       = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    input  logic [DATA_W-1:0]        stored,
    input  logic                     busy,
    output logic [DATA_W-1:0]        rd_data
);

    always_comb begin
        rd_data = stored;
        // Ascending scan so the highest-index matching port is the last to assign.
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[lo_bit(k, AW) +: AW] == rd_addr)) begin
                rd_data = wr_data[lo_bit(k, DATA_W) +: DATA_W];
            end
        end
        if (busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with same-cycle write bypass, write-conflict priority,
// optional zero register and a one-entry-per-cycle clear engine.
module rf_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     busy
);

    rf_state_e         state_q, state_n;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_n;
            clr_ptr_q <= clr_ptr_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        clr_ptr_n = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_n = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_n   = READY;
                    clr_ptr_n = '0;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_n   = CLEAR;
                    clr_ptr_n = '0;
                end
            end
            default: begin
                state_n   = CLEAR;
                clr_ptr_n = '0;
            end
        endcase
    end

    assign busy  = (state_q == CLEAR) || !rst;
    // A clear request takes the array away this cycle, so that cycle's writes are lost.
    assign wr_ok = rst && (state_q == READY) && !clr_req;

    // Storage has no reset; the clear engine provides the defined contents.
    always_ff @(posedge clk) begin
        if (rst && (state_q == CLEAR)) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] &&
                    !((ZERO_REG != 0) && (wr_addr[lo_bit(k, AW) +: AW] == '0))) begin
                    mem[wr_addr[lo_bit(k, AW) +: AW]] <= wr_data[lo_bit(k, DATA_W) +: DATA_W];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[j*AW +: AW];

        rf_bypass_mux #(
            .DATA_W   (DATA_W),
            .AW       (AW),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_addr  (addr),
            .stored   (mem[addr]),
            .busy     (busy),
            .rd_data  (rd_data[j*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: one ZERO_REG=1 instance plus a ZERO_REG=0 twin on the same inputs.
module tb_rf_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    wr_en = '0;
    logic [2*AW-1:0] wr_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data, rd_data_nz;
    logic          clr_req = 1'b0;
    logic          busy, busy_nz;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    rf_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req), .busy(busy)
    );

    rf_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nz), .clr_req(clr_req), .busy(busy_nz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    // Counts cycles with busy high, one clock edge per cycle, bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        // Reset held for three edges.
        step(); step(); step();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rd0", rd_data[0 +: DW], 32'h0);
        check("reset_rd1", rd_data[DW +: DW], 32'h0);
        rst = 1'b1;
        count_busy(n);
        check("reset_clear_len", n, 32'd32);
        check("twin_busy", 32'(busy_nz), 32'd0);

        for (int a = 0; a < 32; a++) begin
            set_rd(0, a[AW-1:0]);
            set_rd(1, a[AW-1:0]);
            #1;
            check("cleared_rd0", rd_data[0 +: DW], 32'h0);
            check("cleared_rd1", rd_data[DW +: DW], 32'h0);
        end

        // Write with same-cycle bypass, then from storage.
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5);
        #1;
        check("bypass_same", rd_data[0 +: DW], 32'hDEADBEEF);
        step();
        set_wr(0, 1'b0, 5'd5, 32'h0);
        #1;
        check("bypass_stored", rd_data[0 +: DW], 32'hDEADBEEF);

        // Write conflict: port 1 wins.
        set_wr(0, 1'b1, 5'd7, 32'h11111111);
        set_wr(1, 1'b1, 5'd7, 32'h22222222);
        set_rd(1, 5'd7);
        #1;
        check("conflict_same", rd_data[DW +: DW], 32'h22222222);
        step();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        check("conflict_stored", rd_data[DW +: DW], 32'h22222222);
        check("addr5_kept", rd_data[0 +: DW], 32'hDEADBEEF);

        // Zero register on one instance, ordinary entry on the other.
        set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(0, 5'd0);
        #1;
        check("zero_same", rd_data[0 +: DW], 32'h0);
        check("nozero_same", rd_data_nz[0 +: DW], 32'hFFFFFFFF);
        step();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("zero_stored", rd_data[0 +: DW], 32'h0);
        check("nozero_stored", rd_data_nz[0 +: DW], 32'hFFFFFFFF);

        // Clear request with a write in the same cycle and writes during clearing.
        set_wr(0, 1'b1, 5'd3, 32'hA5A5A5A5);
        step();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd3);
        #1;
        check("fill_addr3", rd_data[0 +: DW], 32'hA5A5A5A5);
        clr_req = 1'b1;
        set_wr(0, 1'b1, 5'd9, 32'h00001234);
        step();
        clr_req = 1'b0;
        set_wr(1, 1'b1, 5'd3, 32'hCAFEF00D);
        #1;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_rd_zero", rd_data[0 +: DW], 32'h0);
        count_busy(n);
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_wr(1, 1'b0, 5'd0, 32'h0);
        check("clr_len", n, 32'd32);
        set_rd(0, 5'd3);
        set_rd(1, 5'd9);
        #1;
        check("clr_addr3", rd_data[0 +: DW], 32'h0);
        check("clr_addr9", rd_data[DW +: DW], 32'h0);

        // Reset in the middle of a clear restarts it.
        set_wr(0, 1'b1, 5'd20, 32'h5A5A0F0F);
        step();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd20);
        #1;
        check("fill_addr20", rd_data[0 +: DW], 32'h5A5A0F0F);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b0;
        #1;
        check("midclr_rst_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        count_busy(n);
        check("midclr_len", n, 32'd32);
        #1;
        check("midclr_addr20", rd_data[0 +: DW], 32'h0);

        // First write after clearing is accepted.
        set_wr(1, 1'b1, 5'd31, 32'h0BADC0DE);
        step();
        set_wr(1, 1'b0, 5'd0, 32'h0);
        set_rd(1, 5'd31);
        #1;
        check("post_clear_wr", rd_data[DW +: DW], 32'h0BADC0DE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
